// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-through data cache.
package dcache_pkg;

    localparam int unsigned DefIdxW = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StFill  = 2'd2
    } state_e;

    // Each line holds one word, so two byte-offset bits sit below the index.
    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned idx_w);
        return addr_w - idx_w - 2;
    endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// Request/acknowledge bus between the data cache and the backing memory.
interface dcache_wt_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read, one synchronous write, sync valid clear.
module dcache_array import dcache_pkg::*; #(
    parameter int unsigned IDX_W = DefIdxW,
    parameter int unsigned TAG_W = tag_width(32, IDX_W)
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic [IDX_W-1:0] ridx_i,
    output logic             rvalid_o,
    output logic [TAG_W-1:0] rtag_o,
    output logic [31:0]      rdata_o,
    input  logic             we_i,
    input  logic             vset_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  logic [31:0]      wdata_i
);
    localparam int unsigned Lines = 1 << IDX_W;

    logic [Lines-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            valid_q <= '0;
        end else if (we_i && vset_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with a one-entry write buffer.
module dcache_wt import dcache_pkg::*; #(
    parameter int unsigned IDX_W  = DefIdxW,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              mem_stall_o,
    dcache_wt_if.master       bm
);
    localparam int unsigned TagW = tag_width(ADDR_W, IDX_W);

    state_e state_q, state_d;

    logic              bm_req_q, bm_req_d;
    logic              bm_we_q, bm_we_d;
    logic [ADDR_W-1:0] bm_addr_q, bm_addr_d;
    logic [31:0]       bm_wdata_q, bm_wdata_d;

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-3:0] wb_addr_q, wb_addr_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic [IDX_W-1:0] idx;
    logic [TagW-1:0]  tag;
    logic             line_valid;
    logic [TagW-1:0]  line_tag;
    logic [31:0]      line_data;
    logic             hit, is_load, is_store, wb_match, store_acc, fill_done;

    logic             arr_we, arr_vset;
    logic [IDX_W-1:0] arr_widx;
    logic [TagW-1:0]  arr_wtag;
    logic [31:0]      arr_wdata;
    logic             stall;
    logic             unused_byte_off;

    assign unused_byte_off = ^cpu_addr_i[1:0];

    assign idx       = cpu_addr_i[IDX_W+1:2];
    assign tag       = cpu_addr_i[ADDR_W-1:IDX_W+2];
    assign hit       = line_valid && (line_tag == tag);
    // A simultaneous load and store is handled as a store.
    assign is_store  = cpu_we_i;
    assign is_load   = cpu_re_i && !cpu_we_i;
    assign wb_match  = wb_valid_q && (wb_addr_q == cpu_addr_i[ADDR_W-1:2]);
    assign store_acc = is_store && !wb_valid_q;
    assign fill_done = (state_q == StFill) && bm.ack;

    dcache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TagW)
    ) u_array (
        .clk_i    (clk),
        .clr_ni   (rst),
        .ridx_i   (idx),
        .rvalid_o (line_valid),
        .rtag_o   (line_tag),
        .rdata_o  (line_data),
        .we_i     (arr_we),
        .vset_i   (arr_vset),
        .widx_i   (arr_widx),
        .wtag_i   (arr_wtag),
        .wdata_i  (arr_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            bm_req_q   <= 1'b0;
            bm_we_q    <= 1'b0;
            bm_addr_q  <= '0;
            bm_wdata_q <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bm_req_q   <= bm_req_d;
            bm_we_q    <= bm_we_d;
            bm_addr_q  <= bm_addr_d;
            bm_wdata_q <= bm_wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bm_req_d   = bm_req_q;
        bm_we_d    = bm_we_q;
        bm_addr_d  = bm_addr_q;
        bm_wdata_d = bm_wdata_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            StIdle: begin
                // Pending buffer always drains first so memory sees program order.
                if (wb_valid_q) begin
                    state_d    = StDrain;
                    bm_req_d   = 1'b1;
                    bm_we_d    = 1'b1;
                    bm_addr_d  = {wb_addr_q, 2'b00};
                    bm_wdata_d = wb_data_q;
                end else if (is_load && !hit) begin
                    state_d   = StFill;
                    bm_req_d  = 1'b1;
                    bm_we_d   = 1'b0;
                    bm_addr_d = {cpu_addr_i[ADDR_W-1:2], 2'b00};
                end
            end
            StDrain: begin
                if (bm.ack) begin
                    state_d    = StIdle;
                    bm_req_d   = 1'b0;
                    wb_valid_d = 1'b0;
                end
            end
            StFill: begin
                if (bm.ack) begin
                    state_d  = StIdle;
                    bm_req_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (store_acc) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = cpu_addr_i[ADDR_W-1:2];
            wb_data_d  = cpu_wdata_i;
        end
    end

    always_comb begin
        stall       = 1'b0;
        cpu_rdata_o = '0;
        if (is_store) begin
            stall = wb_valid_q;
        end else if (is_load) begin
            if (wb_valid_q) begin
                stall = !(wb_match && hit);
            end else begin
                stall = !((state_q == StIdle) && hit);
            end
            if (!stall) begin
                cpu_rdata_o = wb_match ? wb_data_q : line_data;
            end
        end
        mem_stall_o = stall;

        // Fill refills from the latched request address; a store hit updates in place.
        arr_we    = rst && (fill_done || (store_acc && hit));
        arr_vset  = fill_done;
        arr_widx  = fill_done ? bm_addr_q[IDX_W+1:2] : idx;
        arr_wtag  = fill_done ? bm_addr_q[ADDR_W-1:IDX_W+2] : tag;
        arr_wdata = fill_done ? bm.rdata : cpu_wdata_i;
    end

    assign bm.req   = bm_req_q;
    assign bm.we    = bm_we_q;
    assign bm.addr  = bm_addr_q;
    assign bm.wdata = bm_wdata_q;

endmodule
